// File: rtl/fib_seq_ctrl.sv
// Command-driven sequencer for the Fibonacci datapath: clear, paced step pulses, pause/resume/stop, result capture.
// Define FIB_SEQ_CYCLE_CNT_EN to add the run_cycles counter output.
module fib_seq_ctrl #(
    parameter int VAL_WIDTH  = 30,
    parameter int CNT_WIDTH  = 16,
    parameter int RATE_WIDTH = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_steps,
    input  logic [RATE_WIDTH-1:0] cmd_rate,
    output logic                  fib_clear,
    output logic                  fib_step,
    input  logic [VAL_WIDTH-1:0]  fib_val,
    input  logic                  fib_ovf,
    output logic [VAL_WIDTH-1:0]  result,
    output logic [CNT_WIDTH-1:0]  steps_done,
    output logic [1:0]            status,
    output logic                  busy,
    output logic                  irq_done
`ifdef FIB_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]           run_cycles
`endif
);

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    localparam logic [1:0] ST_COMPLETE = 2'b00;
    localparam logic [1:0] ST_STOPPED  = 2'b01;
    localparam logic [1:0] ST_OVERFLOW = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  ready_en;
    logic [CNT_WIDTH-1:0]  target;
    logic [RATE_WIDTH-1:0] rate;
    logic [RATE_WIDTH-1:0] prescaler;

    logic cmd_fire;
    logic ovf_hit;
    logic tgt_hit;
    logic complete;
    logic count_go;
    logic step_go;

    // State register.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completion always beats a command in RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (cmd_fire && cmd_op == OP_START) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = RUN;
            end
            RUN: begin
                if (complete) begin
                    state_next = DONE;
                end else if (cmd_fire) begin
                    case (cmd_op)
                        OP_START: state_next = CLEAR;
                        OP_STOP:  state_next = DONE;
                        OP_PAUSE: state_next = PAUSED;
                        default:  state_next = RUN;
                    endcase
                end
            end
            PAUSED: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_START:  state_next = CLEAR;
                        OP_STOP:   state_next = DONE;
                        OP_RESUME: state_next = RUN;
                        default:   state_next = PAUSED;
                    endcase
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. The target check waits until the pulse issued last cycle has landed in fib_val.
    always_comb begin
        ovf_hit  = 1'b0;
        tgt_hit  = 1'b0;
        count_go = 1'b0;
        step_go  = 1'b0;
        if (state == RUN) begin
            ovf_hit = fib_ovf;
            tgt_hit = !fib_ovf && (steps_done == target) && !fib_step;
        end
        complete  = ovf_hit || tgt_hit;
        cmd_ready = ready_en && (state != CLEAR) && !complete;
        cmd_fire  = cmd_valid && cmd_ready;
        if (state == RUN && !complete && !(cmd_fire && cmd_op != OP_RESUME)) begin
            count_go = 1'b1;
            step_go  = (prescaler == rate) && (steps_done < target);
        end
    end

    // Registered strobes derived from the upcoming state.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            ready_en  <= 1'b0;
            fib_clear <= 1'b0;
            fib_step  <= 1'b0;
            busy      <= 1'b0;
            irq_done  <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            fib_clear <= (state_next == CLEAR);
            fib_step  <= step_go;
            busy      <= (state_next == CLEAR) || (state_next == RUN) || (state_next == PAUSED);
            irq_done  <= (state_next == DONE) && (state != DONE);
        end
    end

    // Command latches, step pacing and result capture.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            target     <= '0;
            rate       <= '0;
            prescaler  <= '0;
            steps_done <= '0;
            result     <= '0;
            status     <= ST_COMPLETE;
        end else if (cmd_fire && cmd_op == OP_START) begin
            target     <= cmd_steps;
            rate       <= cmd_rate;
            prescaler  <= '0;
            steps_done <= '0;
            status     <= ST_COMPLETE;
        end else if (complete) begin
            result <= fib_val;
            status <= ovf_hit ? ST_OVERFLOW : ST_COMPLETE;
        end else if (cmd_fire && cmd_op == OP_STOP && (state == RUN || state == PAUSED)) begin
            result <= fib_val;
            status <= ST_STOPPED;
        end else if (step_go) begin
            steps_done <= steps_done + CNT_WIDTH'(1);
            prescaler  <= '0;
        end else if (count_go) begin
            prescaler <= prescaler + RATE_WIDTH'(1);
        end
    end

`ifdef FIB_SEQ_CYCLE_CNT_EN
    // Counts RUN cycles only, so time spent PAUSED is excluded; saturates rather than wrapping.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            run_cycles <= '0;
        end else if (cmd_fire && cmd_op == OP_START) begin
            run_cycles <= '0;
        end else if (state == RUN && run_cycles != 32'hffff_ffff) begin
            run_cycles <= run_cycles + 32'd1;
        end
    end
`endif

endmodule
